bp_me_mem_credit_tracker: RTL and testbench
===========================================

Name: bp_me_mem_credit_tracker

Overview:
Sits directly downstream of the victim cache, between its mem_cmd/mem_resp ports and the memory network toward the UCE/memory side. Buffers outbound memory commands in a 2-entry FIFO. Limits outstanding commands to a credit budget. Passes memory responses back upstream. Produces the credits_full/credits_empty status that the victim cache forwards to the D$.

Parameters:
- msg_width_p, 600: width of one memory message; tied to cce_mem_msg_width_lp at instantiation.
- max_credits_p, 4: maximum outstanding commands; legal range is 1..15.
- credit_width_lp, $clog2(max_credits_p+1): width of the credit counter; localparam.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  one clock; reset is synchronous and active-low.
- mem_cmd_i  in  msg_width_p  command from the victim cache.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  FIFO not full.
- mem_cmd_o  out  msg_width_p  command to the network; head of FIFO.
- mem_cmd_v_o  out  1  command valid toward the network.
- mem_cmd_ready_i  in  1  network accepts the command.
- mem_resp_i  in  msg_width_p  response from the network.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed; equals mem_resp_yumi_i.
- mem_resp_o  out  msg_width_p  response to the victim cache; equals mem_resp_i.
- mem_resp_v_o  out  1  equals mem_resp_v_i.
- mem_resp_yumi_i  in  1  victim cache consumes the response.
- credits_full_o  out  1  count == max_credits_p.
- credits_empty_o  out  1  count == 0.
- credit_err_o  out  1  sticky flag: a response arrived while count == 0.

Behaviour:
- Reset (reset_i low at a clock edge):
  - FIFO emptied, count = 0, credit_err_o = 0.
  - Outputs: mem_cmd_ready_o = 1, mem_cmd_v_o = 0, credits_full_o = 0, credits_empty_o = 1.
  - A reset in mid-operation drops buffered commands and outstanding credits with no flush handshake.
- Command FIFO:
  - 2 entries, registered storage, ready/valid on the input side.
  - Enqueue when mem_cmd_v_i & mem_cmd_ready_o.
  - mem_cmd_ready_o = ~full. It does not depend combinationally on mem_cmd_ready_i.
  - A message enqueued at edge N is presented on mem_cmd_o from cycle N+1. Minimum latency is 1 cycle.
  - Simultaneous enqueue and dequeue while full is not allowed: ready_o is already 0.
  - Simultaneous enqueue and dequeue with 1 entry keeps 1 entry, and the new head is the new message.
- Credit gating:
  - mem_cmd_v_o = fifo_v & ~credits_full_o.
  - Dequeue (send) = mem_cmd_v_o & mem_cmd_ready_i.
  - mem_cmd_o stays stable while mem_cmd_v_o is high and not yet accepted.
- Credit counter:
  - send & ~ret: count+1.
  - ret & ~send: count−1.
  - Both: unchanged.
  - ret = mem_resp_yumi_i.
  - Never exceeds max_credits_p; guaranteed by the gating.
- Underflow:
  - ret with count == 0 and no send in the same cycle leaves count at 0 and sets credit_err_o.
  - credit_err_o is cleared only by reset.
  - ret with count == 0 and a simultaneous send leaves count at 0 and is not an error.
- Response path: purely combinational passthrough, with no storage.
- credits_full_o and credits_empty_o are decoded from the registered count and update the cycle after the event.

Decomposition:
- Shared package (bp_me_pkg): the credit-count typedef sized by credit_width_lp, and the default max_credits_p constant.
- One natural sub-module: the 2-entry FIFO, using bsg_two_fifo with width msg_width_p.
- Counter, gating and error flag are inline.

Test Plan:
1. Reset, then idle: expect mem_cmd_ready_o=1, mem_cmd_v_o=0, credits_empty_o=1, credits_full_o=0, credit_err_o=0.
2. Single command 0xA5 enqueued at cycle 3 with mem_cmd_ready_i=1: mem_cmd_v_o=1 with mem_cmd_o=0xA5 in cycle 4; count=1 and credits_empty_o=0 in cycle 5.
3. Hold mem_cmd_ready_i=0 and push 3 commands: the first two are accepted, mem_cmd_ready_o=0 on the 3rd, and mem_cmd_o stays equal to the first message.
4. max_credits_p=4: send 4 commands with no responses. Expect credits_full_o=1 and mem_cmd_v_o=0 with the 5th command buffered. One mem_resp_yumi_i releases the 5th the next cycle.
5. At count=2, send and yumi in the same cycle: count stays 2 and both flags stay 0.
6. At count=0, pulse mem_resp_v_i/yumi_i with no send: credit_err_o=1 from the next cycle, count stays 0, and the flag clears only after reset_i=0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// ----------------------------------------------------------------------------
// bp_me_pkg
//   Shared definitions for the memory-side credit tracker.
//   - max_credits_dp : default outstanding-command budget.
//   - credit_cnt_t   : credit counter type, wide enough for the whole legal
//                      budget range (1..15).
// ----------------------------------------------------------------------------
package bp_me_pkg;

    localparam int max_credits_dp       = 4;
    localparam int max_credits_legal_gp = 15;
    localparam int credit_width_gp      = $clog2(max_credits_legal_gp + 1);

    typedef logic [credit_width_gp-1:0] credit_cnt_t;

endpackage

// File: rtl/bp_me_mem_credit_tracker_if.sv
// ----------------------------------------------------------------------------
// bp_me_mem_credit_tracker_if
//   Command/response handshake bundle around the credit tracker. Signal names
//   carry the tracker's point of view (_i into the tracker, _o out of it).
//   slave  : the tracker itself.
//   master : whatever drives/observes the tracker (victim cache + network).
// ----------------------------------------------------------------------------
interface bp_me_mem_credit_tracker_if #(
    parameter int msg_width_p = 600
);
    // victim cache -> tracker command
    logic [msg_width_p-1:0] mem_cmd_i;
    logic                   mem_cmd_v_i;
    logic                   mem_cmd_ready_o;
    // tracker -> network command
    logic [msg_width_p-1:0] mem_cmd_o;
    logic                   mem_cmd_v_o;
    logic                   mem_cmd_ready_i;
    // network -> tracker response
    logic [msg_width_p-1:0] mem_resp_i;
    logic                   mem_resp_v_i;
    logic                   mem_resp_yumi_o;
    // tracker -> victim cache response
    logic [msg_width_p-1:0] mem_resp_o;
    logic                   mem_resp_v_o;
    logic                   mem_resp_yumi_i;

    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
        input  mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
        output mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
        output mem_resp_yumi_o, mem_resp_o, mem_resp_v_o
    );

    modport master (
        output mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
        output mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
        input  mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
        input  mem_resp_yumi_o, mem_resp_o, mem_resp_v_o
    );
endinterface

// File: rtl/bsg_two_fifo.sv
// ----------------------------------------------------------------------------
// bsg_two_fifo
//   Two-entry ready/valid FIFO with registered storage.
//   clk_i, reset_i (sync, active-low)
//   data_i/v_i/ready_o : enqueue side, enqueue on v_i & ready_o
//   data_o/v_o/yumi_i  : dequeue side, yumi_i only while v_o is high
// ----------------------------------------------------------------------------
module bsg_two_fifo #(
    parameter int width_p = 600
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem_q [2];
    logic               wptr_q, rptr_q;
    logic               full_q, empty_q;
    logic               enq, deq;

    assign ready_o = ~full_q;
    assign v_o     = ~empty_q;
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ~full_q;
    assign deq     = yumi_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (enq) wptr_q <= ~wptr_q;
            if (deq) rptr_q <= ~rptr_q;
            // Occupancy only moves when exactly one side fires; enq+deq with
            // one entry keeps one entry and the head moves to the new slot.
            if (enq && !deq) begin
                empty_q <= 1'b0;
                full_q  <= (~wptr_q == rptr_q);
            end else if (deq && !enq) begin
                full_q  <= 1'b0;
                empty_q <= (~rptr_q == wptr_q);
            end
        end
    end

    // Payload storage is not reset; validity comes from empty_q alone.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_me_mem_credit_tracker.sv
// ----------------------------------------------------------------------------
// bp_me_mem_credit_tracker
//   Buffers outbound memory commands (2-entry FIFO), caps outstanding
//   commands at max_credits_p, passes responses straight through, and
//   reports credit status upstream.
//   clk_i, reset_i (sync, active-low)
//   mem_if           : cmd in/out and resp in/out handshakes (slave side)
//   credits_full_o   : outstanding count == max_credits_p
//   credits_empty_o  : outstanding count == 0
//   credit_err_o     : sticky, a response returned with no credit outstanding
// ----------------------------------------------------------------------------
module bp_me_mem_credit_tracker
    import bp_me_pkg::*;
#(
    parameter int msg_width_p   = 600,
    parameter int max_credits_p = max_credits_dp
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    bp_me_mem_credit_tracker_if.slave    mem_if,
    output logic                         credits_full_o,
    output logic                         credits_empty_o,
    output logic                         credit_err_o
);
    localparam int credit_width_lp = $clog2(max_credits_p + 1);
    localparam logic [credit_width_lp-1:0] max_cnt_lp = credit_width_lp'(max_credits_p);

    logic [credit_width_lp-1:0] count_q, count_d;
    logic                       err_q, err_d;
    logic                       fifo_v;
    logic                       send, ret;

    bsg_two_fifo #(.width_p(msg_width_p)) cmd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (mem_if.mem_cmd_i),
        .v_i     (mem_if.mem_cmd_v_i),
        .ready_o (mem_if.mem_cmd_ready_o),
        .data_o  (mem_if.mem_cmd_o),
        .v_o     (fifo_v),
        .yumi_i  (send)
    );

    assign credits_full_o  = (count_q == max_cnt_lp);
    assign credits_empty_o = (count_q == '0);
    assign credit_err_o    = err_q;

    // Holding valid low at full budget keeps the head parked in the FIFO,
    // so mem_cmd_o cannot change until the network takes it.
    assign mem_if.mem_cmd_v_o = fifo_v & ~credits_full_o;
    assign send               = mem_if.mem_cmd_v_o & mem_if.mem_cmd_ready_i;
    assign ret                = mem_if.mem_resp_yumi_i;

    assign mem_if.mem_resp_o      = mem_if.mem_resp_i;
    assign mem_if.mem_resp_v_o    = mem_if.mem_resp_v_i;
    assign mem_if.mem_resp_yumi_o = mem_if.mem_resp_yumi_i;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (send && !ret) begin
            count_d = count_q + 1'b1;
        end else if (ret && !send) begin
            // A return with nothing outstanding is flagged and the count
            // saturates at zero instead of wrapping.
            if (count_q == '0) err_d   = 1'b1;
            else               count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bp_me_mem_credit_tracker.sv
module tb_bp_me_mem_credit_tracker;

    localparam int MSG_W = 600;
    localparam int MAXC  = 4;
    typedef logic [MSG_W-1:0] msg_t;

    logic clk = 1'b0;
    logic reset_i;
    logic credits_full_o, credits_empty_o, credit_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    msg_t exp_q[$];
    int   exp_cnt = 0;
    bit   exp_err = 1'b0;
    bit   last_enq;

    always #5 clk = ~clk;

    bp_me_mem_credit_tracker_if #(.msg_width_p(MSG_W)) bus ();

    bp_me_mem_credit_tracker #(
        .msg_width_p   (MSG_W),
        .max_credits_p (MAXC)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .mem_if          (bus),
        .credits_full_o  (credits_full_o),
        .credits_empty_o (credits_empty_o),
        .credit_err_o    (credit_err_o)
    );

    function automatic msg_t b2m(input logic b);
        return msg_t'(b);
    endfunction

    task automatic chk(input string tag, input msg_t obs, input msg_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: waits to mid-cycle, compares every output against
    // the model, then advances the model across the next rising edge.
    task automatic cycle();
        bit exp_rdy, exp_vo, enq, send, ret;
        #4;
        exp_rdy = (exp_q.size() < 2);
        exp_vo  = (exp_q.size() > 0) && (exp_cnt != MAXC);
        chk("cmd_ready", b2m(bus.mem_cmd_ready_o), b2m(exp_rdy));
        chk("cmd_v",     b2m(bus.mem_cmd_v_o),     b2m(exp_vo));
        if (exp_vo) chk("cmd_data", bus.mem_cmd_o, exp_q[0]);
        chk("full",  b2m(credits_full_o),  b2m(exp_cnt == MAXC));
        chk("empty", b2m(credits_empty_o), b2m(exp_cnt == 0));
        chk("err",   b2m(credit_err_o),    b2m(exp_err));
        chk("resp_data", bus.mem_resp_o,         bus.mem_resp_i);
        chk("resp_v",    b2m(bus.mem_resp_v_o),    b2m(bus.mem_resp_v_i));
        chk("resp_yumi", b2m(bus.mem_resp_yumi_o), b2m(bus.mem_resp_yumi_i));
        enq  = bus.mem_cmd_v_i && exp_rdy;
        send = exp_vo && bus.mem_cmd_ready_i;
        ret  = bus.mem_resp_yumi_i;
        @(posedge clk);
        last_enq = 1'b0;
        if (!reset_i) begin
            exp_q.delete();
            exp_cnt = 0;
            exp_err = 1'b0;
        end else begin
            if (send) void'(exp_q.pop_front());
            if (enq) begin
                exp_q.push_back(bus.mem_cmd_i);
                last_enq = 1'b1;
            end
            if (send && !ret) exp_cnt++;
            else if (ret && !send) begin
                if (exp_cnt == 0) exp_err = 1'b1;
                else              exp_cnt--;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input msg_t d, input bit rdy, input bit rv, input bit yumi);
        bus.mem_cmd_v_i     = v;
        bus.mem_cmd_i       = d;
        bus.mem_cmd_ready_i = rdy;
        bus.mem_resp_v_i    = rv;
        bus.mem_resp_yumi_i = yumi;
        bus.mem_resp_i      = {8'hC3, 560'b0, 32'($urandom)};
        cycle();
    endtask

    initial begin
        int pushed;
        reset_i = 1'b0;
        bus.mem_cmd_v_i = 1'b0; bus.mem_cmd_i = '0; bus.mem_cmd_ready_i = 1'b0;
        bus.mem_resp_v_i = 1'b0; bus.mem_resp_i = '0; bus.mem_resp_yumi_i = 1'b0;
        @(posedge clk); #1;
        cycle();
        reset_i = 1'b1;

        // idle after reset
        chk("rst_ready", b2m(bus.mem_cmd_ready_o), b2m(1'b1));
        chk("rst_v",     b2m(bus.mem_cmd_v_o),     b2m(1'b0));
        chk("rst_empty", b2m(credits_empty_o),     b2m(1'b1));
        chk("rst_full",  b2m(credits_full_o),      b2m(1'b0));
        chk("rst_err",   b2m(credit_err_o),        b2m(1'b0));
        drive(0, '0, 0, 0, 0);

        // single command, one-cycle latency, count visible the cycle after send
        drive(1, msg_t'('hA5), 1, 0, 0);
        chk("t2_v",    b2m(bus.mem_cmd_v_o), b2m(1'b1));
        chk("t2_data", bus.mem_cmd_o, msg_t'('hA5));
        drive(0, '0, 1, 0, 0);
        chk("t2_empty", b2m(credits_empty_o), b2m(1'b0));
        drive(0, '0, 0, 1, 1);

        // backpressure: two accepted, third refused, head stays first
        for (int i = 0; i < 3; i++) drive(1, msg_t'(100 + i), 0, 0, 0);
        chk("t3_ready", b2m(bus.mem_cmd_ready_o), b2m(1'b0));
        chk("t3_head",  bus.mem_cmd_o, msg_t'(100));
        repeat (2) drive(0, '0, 0, 0, 0);
        repeat (3) drive(0, '0, 1, 0, 0);
        repeat (2) drive(0, '0, 0, 1, 1);

        // credit exhaustion: 5th command parks until one return
        pushed = 0;
        for (int g = 0; g < 20 && pushed < 5; g++) begin
            drive(1, {8'h5A, 560'b0, 32'(200 + pushed)}, 1, 0, 0);
            if (last_enq) pushed++;
        end
        chk("t4_pushed", msg_t'(pushed), msg_t'(5));
        bus.mem_cmd_v_i = 1'b0;
        #1;
        chk("t4_full", b2m(credits_full_o),  b2m(1'b1));
        chk("t4_v",    b2m(bus.mem_cmd_v_o), b2m(1'b0));
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 1, 1);
        chk("t4_rel_v",    b2m(bus.mem_cmd_v_o), b2m(1'b1));
        chk("t4_rel_data", bus.mem_cmd_o, {8'h5A, 560'b0, 32'(204)});
        drive(0, '0, 1, 0, 0);
        repeat (4) drive(0, '0, 0, 1, 1);

        // count=2 with send and return together
        drive(1, msg_t'(300), 1, 0, 0);
        drive(1, msg_t'(301), 1, 0, 0);
        drive(1, msg_t'(302), 1, 0, 0);
        drive(0, '0, 1, 1, 1);
        chk("t5_full",  b2m(credits_full_o),  b2m(1'b0));
        chk("t5_empty", b2m(credits_empty_o), b2m(1'b0));
        repeat (2) drive(0, '0, 0, 1, 1);
        chk("t5_drained", b2m(credits_empty_o), b2m(1'b1));

        // underflow is sticky until reset
        drive(0, '0, 0, 1, 1);
        chk("t6_err", b2m(credit_err_o), b2m(1'b1));
        repeat (3) drive(0, '0, 0, 0, 0);
        chk("t6_sticky", b2m(credit_err_o), b2m(1'b1));
        reset_i = 1'b0;
        drive(0, '0, 0, 0, 0);
        reset_i = 1'b1;
        chk("t6_clear", b2m(credit_err_o), b2m(1'b0));

        // return at count 0 with a simultaneous send is not an error
        drive(1, msg_t'(400), 1, 0, 0);
        drive(0, '0, 1, 1, 1);
        chk("t6_nerr",  b2m(credit_err_o),    b2m(1'b0));
        chk("t6_empty", b2m(credits_empty_o), b2m(1'b1));

        // mid-operation reset drops buffered commands and credits
        repeat (3) drive(1, msg_t'($urandom), 1, 0, 0);
        drive(1, msg_t'(500), 0, 0, 0);
        reset_i = 1'b0;
        drive(0, '0, 0, 0, 0);
        reset_i = 1'b1;
        chk("mid_rst_v",     b2m(bus.mem_cmd_v_o), b2m(1'b0));
        chk("mid_rst_empty", b2m(credits_empty_o), b2m(1'b1));

        // random traffic, returns only while credits are outstanding
        for (int i = 0; i < 300; i++) begin
            bit y;
            y = (exp_cnt > 0) && ($urandom_range(0, 2) == 0);
            drive(1'($urandom_range(0, 1)), {8'hE7, 560'b0, 32'($urandom)},
                  1'($urandom_range(0, 3) != 0), y, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
